// File: rtl/sram_100_qsys_sysid_v2.sv
// System ID / uptime peripheral on an Avalon-MM slave: constant ID words, a free-running
// 64-bit uptime counter with a coherent hi-word shadow, a control word and R/W scratch words.
module sram_100_qsys_sysid_v2 #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h5FB0_46B2,
  parameter int          READ_LATENCY = 1,
  parameter int          NUM_SCRATCH  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int DATA_W = 32;
  localparam int STAGES = READ_LATENCY;

  localparam logic [3:0] ADDR_ID     = 4'd0;
  localparam logic [3:0] ADDR_TS     = 4'd1;
  localparam logic [3:0] ADDR_CAPS   = 4'd2;
  localparam logic [3:0] ADDR_UP_LO  = 4'd3;
  localparam logic [3:0] ADDR_UP_HI  = 4'd4;
  localparam logic [3:0] ADDR_CTRL   = 4'd5;
  localparam logic [3:0] ADDR_SCR0   = 4'd8;

  localparam logic [DATA_W-1:0] CAPS_WORD =
    {16'h0002, 4'h0, 4'(READ_LATENCY), 8'(NUM_SCRATCH)};

  logic              ctrl_en;
  logic [63:0]       uptime;
  logic [DATA_W-1:0] uptime_hi_shadow;
  logic [DATA_W-1:0] scratch [NUM_SCRATCH];

  logic              rd_acc;
  logic              wr_ctrl;
  logic              uptime_clr;
  logic [DATA_W-1:0] rd_mux;

  logic              vld_p     [STAGES];
  logic [DATA_W-1:0] rd_data_p [STAGES];

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [3:0]        be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // A simultaneous write wins; the read is dropped entirely.
  assign rd_acc     = read & ~write;
  assign wr_ctrl    = write & (address == ADDR_CTRL) & byteenable[0];
  assign uptime_clr = wr_ctrl & writedata[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en          <= 1'b1;
      uptime           <= 64'd0;
      uptime_hi_shadow <= '0;
    end else begin
      if (wr_ctrl) ctrl_en <= writedata[0];
      if (uptime_clr)   uptime <= 64'd0;
      else if (ctrl_en) uptime <= uptime + 64'd1;
      // Latch the hi half with the lo read so a LO/HI pair is coherent.
      if (rd_acc && address == ADDR_UP_LO) uptime_hi_shadow <= uptime[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else if (write) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (address == 4'(8 + i)) scratch[i] <= merge_bytes(scratch[i], writedata, byteenable);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_ID:    rd_mux = SYSTEM_ID;
      ADDR_TS:    rd_mux = TIMESTAMP;
      ADDR_CAPS:  rd_mux = CAPS_WORD;
      ADDR_UP_LO: rd_mux = uptime[31:0];
      ADDR_UP_HI: rd_mux = uptime_hi_shadow;
      ADDR_CTRL:  rd_mux = {31'd0, ctrl_en};
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address == ADDR_SCR0 + 4'(i)) rd_mux = scratch[i];
        end
      end
    endcase
  end

  // Stage p0: capture read data; later stages shift toward the output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (rd_acc) rd_data_p[0] <= rd_mux;
    for (int i = 1; i < STAGES; i++) rd_data_p[i] <= rd_data_p[i-1];
  end

  // Output stage: data is forced to zero whenever the qualifier is low.
  assign readdatavalid = vld_p[STAGES-1];
  assign readdata      = vld_p[STAGES-1] ? rd_data_p[STAGES-1] : '0;

endmodule

// File: doc/sram_100_qsys_sysid_v2.md
SRAM_100_QSYS_SYSID_V2 -- requirements
Module: sram_100_qsys_sysid_v2

Interface
REQ-001 The block SHALL provide these parameters, one per line:
- SYSTEM_ID, 32'h0000_0000, value returned at word 0.
- TIMESTAMP, 32'h5FB0_46B2, build time in epoch seconds, returned at word 1.
- READ_LATENCY, 1, read pipeline depth; legal values 1..3.
- NUM_SCRATCH, 2, number of R/W scratch words; legal values 1..8.

REQ-002 The block SHALL provide these ports, one per line:
- clock, in, 1, single clock; all logic on the rising edge.
- reset_n, in, 1, reset; asynchronous and active-low.
- address, in, 4, Avalon-MM word address.
- read, in, 1, read request.
- write, in, 1, write request.
- writedata, in, 32, write data.
- byteenable, in, 4, write byte lanes.
- readdata, out, 32, read data.
- readdatavalid, out, 1, readdata qualifier.

REQ-003 The slave SHALL have no waitrequest and SHALL accept one transfer per clock.

Function
REQ-004 The register map SHALL be, by word address:
- 0: ID (RO) = SYSTEM_ID.
- 1: TS (RO) = TIMESTAMP.
- 2: CAPS (RO) = {16'h0002, 4'h0, READ_LATENCY[3:0], NUM_SCRATCH[7:0]}.
- 3: UPTIME_LO (RO).
- 4: UPTIME_HI (RO).
- 5: CTRL (R/W).
- 6..7: reserved.
- 8..8+NUM_SCRATCH-1: SCRATCH[n] (R/W).

REQ-005 Reads of reserved or unmapped addresses SHALL return 0; writes to them and to RO words SHALL have no effect.

REQ-006 A read accepted at edge N SHALL capture its data from register state before edge N, and SHALL present that data on readdata with readdatavalid=1 for exactly one cycle, READ_LATENCY cycles later.

REQ-007 Back-to-back reads SHALL each produce one readdatavalid pulse, in order, with no bubbles.

REQ-008 When readdatavalid=0, readdata SHALL be 0.

REQ-009 If read and write are asserted in the same cycle, the block SHALL perform the write and drop the read, producing no readdatavalid.

REQ-010 UPTIME SHALL be a 64-bit counter, reset to 0, that increments by 1 per clock while CTRL.EN=1. It SHALL wrap from 2^64-1 to 0 with no flag.

REQ-011 A read of UPTIME_LO SHALL return UPTIME[31:0] and, on the same edge, load a shadow register with UPTIME[63:32].

REQ-012 A read of UPTIME_HI SHALL return the shadow register, whose reset value is 0.

REQ-013 CTRL SHALL be defined as follows:
- bit0 EN: R/W, reset 1.
- bit1 CLR: write-1 pulse, reads 0.
- bits31:2: read 0.
- CTRL SHALL be written only when byteenable[0]=1.

REQ-014 A CTRL write with CLR=1 SHALL make UPTIME 0 after that edge. CLR SHALL take priority over increment.

REQ-015 The EN value written in the same cycle as CLR SHALL take effect from the next cycle.

REQ-016 SCRATCH writes SHALL update only the bytes whose byteenable bit is 1. byteenable=4'b0000 SHALL leave the word unchanged.

REQ-017 A write and a read of the same register in consecutive cycles SHALL return the newly written value (read-after-write with no hazard).

Reset
REQ-018 Assertion of reset_n=0 SHALL, asynchronously, set the following, and SHALL discard any in-flight reads:
- readdata = 0, readdatavalid = 0, read pipeline empty.
- UPTIME = 0, shadow = 0.
- CTRL.EN = 1.
- All SCRATCH words = 0.

REQ-019 After reset_n deasserts, the first UPTIME increment SHALL occur on the first rising edge with reset_n=1.

Verification
REQ-020 Read addresses 0, 1, 2 with READ_LATENCY=2 and NUM_SCRATCH=2 -> readdata is 0x00000000, 0x5FB046B2, 0x00020202, each with readdatavalid exactly 2 cycles after its request.

REQ-021 Write 0xDEADBEEF to addr 8 with byteenable=4'b1111, then write 0x00001200 with byteenable=4'b0010, then read addr 8 -> 0xDEAD12EF. Read addr 6 -> 0.

REQ-022 Force UPTIME to 0x00000000_FFFFFFFF via the bench backdoor, with EN=0, then read addr 3 then addr 4 -> 0xFFFFFFFF, then 0x00000000. Set EN=1 and let the counter cross the 32-bit boundary; a LO/HI read pair returns a consistent 64-bit value.

REQ-023 Write CTRL=0x3 while the counter is running -> UPTIME reads 0 on the next read. Write CTRL=0x0 -> two reads of addr 3 spaced 10 cycles apart return equal values.

REQ-024 Issue 3 back-to-back reads, then assert reset_n=0 mid-pipeline -> readdatavalid drops to 0 immediately, no stale data appears after release, and SCRATCH reads 0.

REQ-025 Assert read and write together to addr 9 with writedata=0x5A5A5A5A -> no readdatavalid is produced, and a subsequent read of addr 9 returns 0x5A5A5A5A.
